// File: rtl/irq_controller.sv
// Interrupt source for the processor IRQ input: captures edges, masks, prioritises and
// follows the handler from vector fetch until the return to user mode.
module irq_controller #(
  parameter int unsigned NUM_SRC    = 8,
  parameter int unsigned ID_W       = 3,
  parameter logic [31:0] IRQ_VECTOR = 32'h80000008,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic               clk,
  input  logic               RESET_N,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic               mask_we,
  input  logic [NUM_SRC-1:0] mask_wdata,
  input  logic [31:0]        InstAdd,
  output logic               IRQ,
  output logic [ID_W-1:0]    irq_id,
  output logic               in_service,
  output logic [NUM_SRC-1:0] pending,
  output logic               ack_pulse,
  output logic               err_timeout
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

  state_t             state_reg, state_next;
  logic [NUM_SRC-1:0] prev_reg;
  logic [NUM_SRC-1:0] pending_reg, pending_next;
  logic [NUM_SRC-1:0] mask_reg;
  logic [15:0]        cnt_reg, cnt_next;
  logic               irq_reg, irq_next;
  logic [ID_W-1:0]    id_reg, id_next;
  logic               svc_reg, svc_next;
  logic               ack_reg, ack_next;
  logic               err_reg, err_next;

  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] clr;
  logic [ID_W-1:0]    sel_idx;
  logic               ack_now;

  assign eligible = pending_reg & mask_reg;

  // A fresh rise on the source being cleared at ack keeps its pending bit set.
  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
      assign rise[gi]         = irq_src[gi] & ~prev_reg[gi];
      assign clr[gi]          = ack_now && (sel_idx == ID_W'(gi));
      assign pending_next[gi] = rise[gi] | (pending_reg[gi] & ~clr[gi]);
    end
  endgenerate

  // Lowest eligible index has the highest priority.
  always_comb begin
    sel_idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) sel_idx = ID_W'(i);
    end
  end

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      state_reg   <= ST_IDLE;
      prev_reg    <= '0;
      pending_reg <= '0;
      mask_reg    <= '1;
      cnt_reg     <= '0;
      irq_reg     <= 1'b0;
      id_reg      <= '0;
      svc_reg     <= 1'b0;
      ack_reg     <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      prev_reg    <= irq_src;
      pending_reg <= pending_next;
      if (mask_we) mask_reg <= mask_wdata;
      cnt_reg     <= cnt_next;
      irq_reg     <= irq_next;
      id_reg      <= id_next;
      svc_reg     <= svc_next;
      ack_reg     <= ack_next;
      err_reg     <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    irq_next   = irq_reg;
    id_next    = id_reg;
    svc_next   = svc_reg;
    ack_next   = 1'b0;
    err_next   = err_reg;
    ack_now    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        // Never raise a request while the processor is already in supervisor mode.
        if ((|eligible) && !InstAdd[31]) begin
          state_next = ST_ASSERT;
          irq_next   = 1'b1;
          cnt_next   = '0;
        end
      end
      ST_ASSERT: begin
        if (~|eligible) begin
          // Request withdrawn by a mask write; a late vector fetch is ignored.
          state_next = ST_IDLE;
          irq_next   = 1'b0;
        end else if (InstAdd == IRQ_VECTOR) begin
          state_next = ST_SERVICE;
          irq_next   = 1'b0;
          id_next    = sel_idx;
          ack_next   = 1'b1;
          svc_next   = 1'b1;
          ack_now    = 1'b1;
        end else if (cnt_reg == TIMEOUT_C) begin
          state_next = ST_IDLE;
          irq_next   = 1'b0;
          err_next   = 1'b1;
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
      ST_SERVICE: begin
        if (!InstAdd[31]) begin
          state_next = ST_IDLE;
          svc_next   = 1'b0;
        end
      end
      default: begin
        state_next = ST_IDLE;
        irq_next   = 1'b0;
      end
    endcase
  end

  always_comb begin
    IRQ         = irq_reg;
    irq_id      = id_reg;
    in_service  = svc_reg;
    pending     = pending_reg;
    ack_pulse   = ack_reg;
    err_timeout = err_reg;
  end

endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller: directed vector table, hand sequences for timeout and
// asynchronous reset, then random traffic against a behavioural model.
module tb_irq_controller;
  localparam int          N   = 8;
  localparam int          IDW = 3;
  localparam logic [31:0] VEC = 32'h80000008;
  localparam int          TO  = 4;
  localparam logic [31:0] U   = 32'h00000100;

  logic          clk = 1'b0;
  logic          RESET_N;
  logic [N-1:0]  irq_src;
  logic          mask_we;
  logic [N-1:0]  mask_wdata;
  logic [31:0]   InstAdd;
  logic          IRQ;
  logic [IDW-1:0] irq_id;
  logic          in_service;
  logic [N-1:0]  pending;
  logic          ack_pulse;
  logic          err_timeout;

  always #5 clk = ~clk;

  irq_controller #(.NUM_SRC(N), .ID_W(IDW), .IRQ_VECTOR(VEC), .TIMEOUT(TO)) dut (
    .clk(clk), .RESET_N(RESET_N), .irq_src(irq_src), .mask_we(mask_we),
    .mask_wdata(mask_wdata), .InstAdd(InstAdd), .IRQ(IRQ), .irq_id(irq_id),
    .in_service(in_service), .pending(pending), .ack_pulse(ack_pulse),
    .err_timeout(err_timeout)
  );

  typedef struct {
    logic [7:0]  src;
    logic        we;
    logic [7:0]  wd;
    logic [31:0] addr;
    logic        irq;
    logic [2:0]  id;
    logic        svc;
    logic [7:0]  pend;
    logic        ack;
    logic        err;
  } vec_t;

  vec_t tbl[49];
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference model state: phase 0 = quiet, 1 = request outstanding, 2 = handler running.
  logic [7:0] m_prev, m_pend, m_mask;
  int         m_phase, m_wait, m_id;
  logic       m_irq, m_svc, m_ack, m_err;

  function automatic vec_t mk(logic [7:0] s, logic we, logic [7:0] wd, logic [31:0] a,
                              logic irq, logic [2:0] id, logic svc, logic [7:0] pend,
                              logic ack, logic err);
    vec_t v;
    v.src = s; v.we = we; v.wd = wd; v.addr = a;
    v.irq = irq; v.id = id; v.svc = svc; v.pend = pend; v.ack = ack; v.err = err;
    return v;
  endfunction

  function automatic logic [14:0] pack(logic irq, logic [2:0] id, logic svc, logic [7:0] pend,
                                       logic ack, logic err);
    return {irq, id, svc, pend, ack, err};
  endfunction

  task automatic check(input string name, input logic [14:0] exp, input bit verbose);
    logic [14:0] got;
    got = {IRQ, irq_id, in_service, pending, ack_pulse, err_timeout};
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got irq=%b id=%0d svc=%b pend=%h ack=%b err=%b, want irq=%b id=%0d svc=%b pend=%h ack=%b err=%b",
               name, got[14], got[13:11], got[10], got[9:2], got[1], got[0],
               exp[14], exp[13:11], exp[10], exp[9:2], exp[1], exp[0]);
    end else if (verbose) begin
      $display("ok   %s: irq=%b id=%0d svc=%b pend=%h ack=%b err=%b",
               name, got[14], got[13:11], got[10], got[9:2], got[1], got[0]);
    end
  endtask

  task automatic model_reset();
    m_prev = '0; m_pend = '0; m_mask = '1;
    m_phase = 0; m_wait = 0; m_id = 0;
    m_irq = 0; m_svc = 0; m_ack = 0; m_err = 0;
  endtask

  // Advances the model by one clock using the inputs currently on the pins.
  task automatic model_step();
    logic [7:0] rise, elig, np;
    int sel;
    rise = irq_src & ~m_prev;
    elig = m_pend & m_mask;
    sel = -1;
    for (int i = 0; i < 8; i++) if (elig[i] && sel < 0) sel = i;
    np = m_pend | rise;
    m_ack = 0;
    case (m_phase)
      0: if (sel >= 0 && !InstAdd[31]) begin m_phase = 1; m_irq = 1; m_wait = 0; end
      1: begin
        if (sel < 0) begin
          m_phase = 0; m_irq = 0;
        end else if (InstAdd == VEC) begin
          m_irq = 0; m_id = sel; np[sel] = rise[sel]; m_ack = 1; m_svc = 1; m_phase = 2;
        end else if (m_wait == TO) begin
          m_irq = 0; m_err = 1; m_phase = 0;
        end else begin
          m_wait++;
        end
      end
      2: if (!InstAdd[31]) begin m_svc = 0; m_phase = 0; end
      default: ;
    endcase
    m_pend = np;
    if (mask_we) m_mask = mask_wdata;
    m_prev = irq_src;
  endtask

  task automatic step(input logic [7:0] s, input logic we, input logic [7:0] wd, input logic [31:0] a);
    irq_src = s; mask_we = we; mask_wdata = wd; InstAdd = a;
    model_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = mk(8'h04, 0, 8'h00, U,            0, 0, 0, 8'h04, 0, 0);
    tbl[1]  = mk(8'h00, 0, 8'h00, U,            1, 0, 0, 8'h04, 0, 0);
    tbl[2]  = mk(8'h00, 0, 8'h00, VEC,          0, 2, 1, 8'h00, 1, 0);
    tbl[3]  = mk(8'h00, 0, 8'h00, 32'h80000010, 0, 2, 1, 8'h00, 0, 0);
    tbl[4]  = mk(8'h00, 0, 8'h00, U,            0, 2, 0, 8'h00, 0, 0);
    tbl[5]  = mk(8'h22, 0, 8'h00, U,            0, 2, 0, 8'h22, 0, 0);
    tbl[6]  = mk(8'h22, 0, 8'h00, U,            1, 2, 0, 8'h22, 0, 0);
    tbl[7]  = mk(8'h22, 0, 8'h00, VEC,          0, 1, 1, 8'h20, 1, 0);
    tbl[8]  = mk(8'h00, 0, 8'h00, 32'h80000020, 0, 1, 1, 8'h20, 0, 0);
    tbl[9]  = mk(8'h00, 0, 8'h00, 32'h000003C4, 0, 1, 0, 8'h20, 0, 0);
    tbl[10] = mk(8'h00, 0, 8'h00, 32'h000003C4, 1, 1, 0, 8'h20, 0, 0);
    tbl[11] = mk(8'h00, 0, 8'h00, VEC,          0, 5, 1, 8'h00, 1, 0);
    tbl[12] = mk(8'h01, 0, 8'h00, 32'h80000040, 0, 5, 1, 8'h01, 0, 0);
    tbl[13] = mk(8'h00, 0, 8'h00, 32'h000003B8, 0, 5, 0, 8'h01, 0, 0);
    tbl[14] = mk(8'h00, 0, 8'h00, 32'h80000040, 0, 5, 0, 8'h01, 0, 0);
    tbl[15] = mk(8'h00, 0, 8'h00, 32'h80000040, 0, 5, 0, 8'h01, 0, 0);
    tbl[16] = mk(8'h00, 0, 8'h00, 32'h000003B8, 1, 5, 0, 8'h01, 0, 0);
    tbl[17] = mk(8'h00, 0, 8'h00, VEC,          0, 0, 1, 8'h00, 1, 0);
    tbl[18] = mk(8'h00, 0, 8'h00, U,            0, 0, 0, 8'h00, 0, 0);
    tbl[19] = mk(8'h00, 1, 8'hFE, U,            0, 0, 0, 8'h00, 0, 0);
    tbl[20] = mk(8'h01, 0, 8'h00, U,            0, 0, 0, 8'h01, 0, 0);
    tbl[21] = mk(8'h01, 0, 8'h00, U,            0, 0, 0, 8'h01, 0, 0);
    tbl[22] = mk(8'h01, 1, 8'hFF, U,            0, 0, 0, 8'h01, 0, 0);
    tbl[23] = mk(8'h01, 0, 8'h00, U,            1, 0, 0, 8'h01, 0, 0);
    tbl[24] = mk(8'h01, 0, 8'h00, VEC,          0, 0, 1, 8'h00, 1, 0);
    tbl[25] = mk(8'h00, 0, 8'h00, U,            0, 0, 0, 8'h00, 0, 0);
    tbl[26] = mk(8'h08, 0, 8'h00, U,            0, 0, 0, 8'h08, 0, 0);
    tbl[27] = mk(8'h00, 0, 8'h00, U,            1, 0, 0, 8'h08, 0, 0);
    tbl[28] = mk(8'h00, 1, 8'hF7, U,            1, 0, 0, 8'h08, 0, 0);
    tbl[29] = mk(8'h00, 0, 8'h00, VEC,          0, 0, 0, 8'h08, 0, 0);
    tbl[30] = mk(8'h00, 1, 8'hFF, U,            0, 0, 0, 8'h08, 0, 0);
    tbl[31] = mk(8'h00, 0, 8'h00, U,            1, 0, 0, 8'h08, 0, 0);
    tbl[32] = mk(8'h00, 0, 8'h00, VEC,          0, 3, 1, 8'h00, 1, 0);
    tbl[33] = mk(8'h00, 0, 8'h00, U,            0, 3, 0, 8'h00, 0, 0);
    tbl[34] = mk(8'h10, 0, 8'h00, U,            0, 3, 0, 8'h10, 0, 0);
    tbl[35] = mk(8'h00, 0, 8'h00, U,            1, 3, 0, 8'h10, 0, 0);
    tbl[36] = mk(8'h10, 0, 8'h00, VEC,          0, 4, 1, 8'h10, 1, 0);
    tbl[37] = mk(8'h10, 0, 8'h00, U,            0, 4, 0, 8'h10, 0, 0);
    tbl[38] = mk(8'h10, 0, 8'h00, U,            1, 4, 0, 8'h10, 0, 0);
    tbl[39] = mk(8'h10, 0, 8'h00, VEC,          0, 4, 1, 8'h00, 1, 0);
    tbl[40] = mk(8'h10, 0, 8'h00, U,            0, 4, 0, 8'h00, 0, 0);
    tbl[41] = mk(8'h40, 0, 8'h00, U,            0, 4, 0, 8'h40, 0, 0);
    tbl[42] = mk(8'h40, 0, 8'h00, U,            1, 4, 0, 8'h40, 0, 0);
    tbl[43] = mk(8'h42, 0, 8'h00, U,            1, 4, 0, 8'h42, 0, 0);
    tbl[44] = mk(8'h42, 0, 8'h00, VEC,          0, 1, 1, 8'h40, 1, 0);
    tbl[45] = mk(8'h42, 0, 8'h00, U,            0, 1, 0, 8'h40, 0, 0);
    tbl[46] = mk(8'h42, 0, 8'h00, U,            1, 1, 0, 8'h40, 0, 0);
    tbl[47] = mk(8'h42, 0, 8'h00, VEC,          0, 6, 1, 8'h00, 1, 0);
    tbl[48] = mk(8'h42, 0, 8'h00, U,            0, 6, 0, 8'h00, 0, 0);

    RESET_N = 1'b0; irq_src = '0; mask_we = 1'b0; mask_wdata = '0; InstAdd = U;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 15'h0, 1);
    RESET_N = 1'b1;

    for (int i = 0; i < 49; i++) begin
      step(tbl[i].src, tbl[i].we, tbl[i].wd, tbl[i].addr);
      check($sformatf("table[%0d]", i),
            pack(tbl[i].irq, tbl[i].id, tbl[i].svc, tbl[i].pend, tbl[i].ack, tbl[i].err), 1);
    end

    // Timeout: five cycles of IRQ, drop with sticky error, pending kept, re-assert.
    step(8'h80, 0, 8'h00, U);
    check("to_pending", pack(0, 6, 0, 8'h80, 0, 0), 1);
    for (int k = 0; k < 5; k++) begin
      step(8'h00, 0, 8'h00, U);
      check($sformatf("to_assert[%0d]", k), pack(1, 6, 0, 8'h80, 0, 0), 1);
    end
    step(8'h00, 0, 8'h00, U);
    check("to_expire", pack(0, 6, 0, 8'h80, 0, 1), 1);
    step(8'h00, 0, 8'h00, U);
    check("to_reassert", pack(1, 6, 0, 8'h80, 0, 1), 1);
    step(8'h00, 0, 8'h00, VEC);
    check("to_ack", pack(0, 7, 1, 8'h00, 1, 1), 1);
    step(8'h00, 0, 8'h00, 32'h80000100);
    check("svc_hold", pack(0, 7, 1, 8'h00, 0, 1), 1);

    // Asynchronous reset in the middle of a cycle while in service.
    #3;
    RESET_N = 1'b0;
    model_reset();
    #1;
    check("async_rst", 15'h0, 1);
    @(posedge clk);
    #1;
    RESET_N = 1'b1;
    step(8'h01, 0, 8'h00, U);
    check("post_rst_pend", pack(0, 0, 0, 8'h01, 0, 0), 1);
    step(8'h00, 0, 8'h00, U);
    check("post_rst_mask", pack(1, 0, 0, 8'h01, 0, 0), 1);
    step(8'h00, 0, 8'h00, VEC);
    check("post_rst_ack", pack(0, 0, 1, 8'h00, 1, 0), 1);

    // Random traffic against the behavioural model.
    for (int n = 0; n < 1500; n++) begin
      logic [7:0]  s, wd;
      logic        we;
      logic [31:0] a;
      int          r;
      s  = 8'($urandom) & 8'($urandom) & 8'($urandom);
      we = ($urandom_range(0, 15) == 0);
      wd = 8'($urandom) | 8'($urandom);
      r  = $urandom_range(0, 9);
      if (r < 3)      a = VEC;
      else if (r < 7) a = {1'b0, 31'($urandom)};
      else            a = {1'b1, 31'($urandom)};
      step(s, we, wd, a);
      check($sformatf("rand[%0d]", n), pack(m_irq, 3'(m_id), m_svc, m_pend, m_ack, m_err), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
